// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, register-0 constant and write-port priority helper
package regfile_pkg;
   localparam int DEF_XLEN = 32;
   localparam int DEF_NREG = 32;
   localparam int DEF_NRD  = 2;
   localparam int DEF_NWR  = 2;
   localparam int MAX_NWR  = 4;
   localparam int ZERO_REG = 0;

   // Highest-index asserted bit of a per-port hit vector (the winning writer); 0 when none hit.
   function automatic logic [1:0] win_port(input logic [MAX_NWR-1:0] hit);
      win_port = '0;
      for (int j = 0; j < MAX_NWR; j++)
         if (hit[j]) win_port = 2'(j);
   endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy bits with reservation acceptance and writeback clear
module reg_scoreboard import regfile_pkg::*; #(
   parameter int NREG = DEF_NREG,
   parameter int NWR  = DEF_NWR,
   localparam int AW  = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NWR-1:0]    we,
   input  logic [NWR*AW-1:0] wa,
   input  logic              rsv_valid,
   input  logic [AW-1:0]     rsv_addr,
   output logic              rsv_ok,
   output logic [NREG-1:0]   busy_vec
);
   logic [NREG-1:0] clr;
   logic [NREG-1:0] set;

   // Registers being written back this cycle release their busy bit.
   always_comb begin
      clr = '0;
      for (int j = 0; j < NWR; j++)
         if (we[j]) clr[wa[j*AW +: AW]] = 1'b1;
   end

   // A reservation is refused only when the target still has a pending writer that is not retiring now.
   assign rsv_ok = !rst && rsv_valid &&
                   (rsv_addr == AW'(ZERO_REG) || !busy_vec[rsv_addr] || clr[rsv_addr]);
   assign set = rsv_ok ? NREG'(1) << rsv_addr : '0;

   // Set beats clear so the newly issued producer owns the register; bit 0 never becomes busy.
   always_ff @(posedge clk)
      busy_vec <= rst ? '0 : ((busy_vec & ~clr) | set) & ~NREG'(1);
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with optional write bypass and busy scoreboard
module regfile_sb import regfile_pkg::*; #(
   parameter int XLEN   = DEF_XLEN,
   parameter int NREG   = DEF_NREG,
   parameter int NRD    = DEF_NRD,
   parameter int NWR    = DEF_NWR,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      we,
   input  logic [NWR*AW-1:0]   wa,
   input  logic [NWR*XLEN-1:0] wd,
   input  logic                rsv_valid,
   input  logic [AW-1:0]       rsv_addr,
   output logic                rsv_ok,
   output logic [NREG-1:0]     busy_vec
);
   logic [XLEN-1:0] mem [NREG];

   function automatic logic [MAX_NWR-1:0] hits(input logic [AW-1:0] a, input logic [NWR-1:0] w,
                                               input logic [NWR*AW-1:0] x);
      hits = '0;
      for (int j = 0; j < NWR; j++)
         hits[j] = w[j] && x[j*AW +: AW] == a;
   endfunction

   reg_scoreboard #(.NREG(NREG), .NWR(NWR)) u_sb (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .rsv_valid(rsv_valid),
      .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .busy_vec(busy_vec)
   );

   // Array update: the highest-index port targeting a register supplies its data; register 0 is never written.
   always_ff @(posedge clk)
      if (rst)
         for (int r = 0; r < NREG; r++) mem[r] <= '0;
      else
         for (int r = 1; r < NREG; r++)
            if (|hits(AW'(r), we, wa))
               mem[r] <= wd[int'(win_port(hits(AW'(r), we, wa)))*XLEN +: XLEN];

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]      a;
      logic [MAX_NWR-1:0] h;
      logic               byp;
      assign a   = rd_addr[i*AW +: AW];
      assign h   = hits(a, we, wa);
      assign byp = BYPASS != 0 && !rst && |h;
      assign rd_data[i*XLEN +: XLEN] = a == AW'(ZERO_REG) ? '0 :
                                       byp ? wd[int'(win_port(h))*XLEN +: XLEN] : mem[a];
      assign rd_busy[i] = a != AW'(ZERO_REG) && !byp && busy_vec[a];
   end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scoreboard bench driving a bypass and a non-bypass instance in lockstep
module tb_regfile_sb;
   logic        clk = 0;
   logic        rst = 1;
   logic [9:0]  rd_addr = '0;
   logic [1:0]  we = '0;
   logic [9:0]  wa = '0;
   logic [63:0] wd = '0;
   logic        rsv_valid = 0;
   logic [4:0]  rsv_addr = '0;
   logic [63:0] rd_data_b, rd_data_n;
   logic [1:0]  rd_busy_b, rd_busy_n;
   logic        rsv_ok_b, rsv_ok_n;
   logic [31:0] busy_vec_b, busy_vec_n;

   regfile_sb #(.BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .we(we), .wa(wa), .wd(wd), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
      .rsv_ok(rsv_ok_b), .busy_vec(busy_vec_b)
   );
   regfile_sb #(.BYPASS(0)) dut_n (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .we(we), .wa(wa), .wd(wd), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
      .rsv_ok(rsv_ok_n), .busy_vec(busy_vec_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      int          sig;
      logic [63:0] val;
      string       name;
   } exp_t;

   localparam int RD0_B = 0, RD0_N = 1, BSY_B = 2, OK_B = 3, BV_B = 4, BV_N = 5, RD1_B = 6, BSY_N = 7, OK_N = 8;

   exp_t        q[$];
   exp_t        e;
   logic [63:0] act;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] sel(input int s);
      case (s)
         RD0_B:   sel = {32'h0, rd_data_b[31:0]};
         RD0_N:   sel = {32'h0, rd_data_n[31:0]};
         BSY_B:   sel = {62'h0, rd_busy_b};
         OK_B:    sel = {63'h0, rsv_ok_b};
         BV_B:    sel = {32'h0, busy_vec_b};
         BV_N:    sel = {32'h0, busy_vec_n};
         RD1_B:   sel = {32'h0, rd_data_b[63:32]};
         BSY_N:   sel = {62'h0, rd_busy_n};
         default: sel = {63'h0, rsv_ok_n};
      endcase
   endfunction

   always @(negedge clk)
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         act = sel(e.sig);
         n_cmp++;
         if (e.cyc != cyc || act !== e.val) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", e.name, e.cyc, act, e.val);
         end
      end

   task automatic push(input int s, input logic [63:0] v, input string n);
      q.push_back('{cyc, s, v, n});
   endtask

   task automatic step(input logic r, input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1, input logic rv, input logic [4:0] ra,
                       input logic [4:0] r0, input logic [4:0] r1);
      @(posedge clk);
      #1;
      rst = r; we = w; wa = {a1, a0}; wd = {d1, d0};
      rsv_valid = rv; rsv_addr = ra; rd_addr = {r1, r0};
   endtask

   initial begin
      step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 2'b01, 5, 32'hDEAD_BEEF, 0, 0, 1, 4, 5, 0);
      push(OK_B, 0, "rsv_ok_in_reset");
      push(RD0_B, 0, "bypass_off_in_reset");
      step(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 0);
      push(RD0_B, 0, "reset_write_dropped");
      push(BV_B, 0, "busy_after_reset");
      push(BSY_B, 0, "rd_busy_after_reset");
      step(0, 2'b01, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 5, 0);
      push(RD0_B, 32'hDEAD_BEEF, "r5_bypass");
      push(RD0_N, 0, "r5_nobypass_old");
      step(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 0);
      push(RD0_N, 32'hDEAD_BEEF, "r5_stored");
      step(1, 2'b00, 0, 0, 0, 0, 1, 6, 5, 0);
      push(OK_N, 0, "rsv_ok_in_reset2");
      step(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 0);
      push(RD0_B, 0, "r5_cleared_b");
      push(RD0_N, 0, "r5_cleared_n");
      push(BV_N, 0, "rsv_in_reset_dropped");
      step(0, 2'b01, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0);
      push(RD0_B, 0, "r0_bypass_blocked");
      push(OK_B, 1, "r0_rsv_ok");
      push(BSY_B, 0, "r0_rd_busy");
      step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
      push(RD0_N, 0, "r0_stays_zero");
      push(BV_B, 0, "r0_never_busy");
      step(0, 2'b01, 7, 32'h1234_5678, 0, 0, 0, 0, 7, 0);
      push(RD0_B, 32'h1234_5678, "r7_bypass");
      push(RD0_N, 0, "r7_nobypass_old");
      step(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 0);
      push(RD0_N, 32'h1234_5678, "r7_stored");
      step(0, 2'b11, 3, 32'h1, 3, 32'h2, 0, 0, 3, 7);
      push(RD0_B, 32'h2, "conflict_bypass");
      push(RD0_N, 0, "conflict_nobypass_old");
      push(RD1_B, 32'h1234_5678, "port1_r7");
      step(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 0);
      push(RD0_B, 32'h2, "conflict_stored_b");
      push(RD0_N, 32'h2, "conflict_stored_n");
      step(0, 2'b00, 0, 0, 0, 0, 1, 9, 9, 0);
      push(OK_B, 1, "r9_rsv_first");
      push(BSY_B, 0, "r9_not_busy_yet");
      step(0, 2'b00, 0, 0, 0, 0, 1, 9, 9, 0);
      push(OK_B, 0, "r9_rsv_denied");
      push(BV_B, 32'h200, "r9_busy_b");
      push(BSY_N, 2'b01, "r9_rd_busy");
      step(0, 2'b01, 9, 32'hAA, 0, 0, 1, 9, 9, 0);
      push(OK_N, 1, "r9_rsv_with_write");
      push(BV_N, 32'h200, "r9_busy_after_deny");
      push(BSY_B, 0, "r9_busy_bypassed");
      push(BSY_N, 2'b01, "r9_busy_nobypass");
      push(RD0_B, 32'hAA, "r9_data_bypass");
      step(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0);
      push(BV_B, 32'h200, "r9_set_wins");
      push(BSY_B, 2'b01, "r9_rd_busy_kept");
      step(0, 2'b01, 9, 32'hBB, 0, 0, 0, 0, 9, 0);
      push(BSY_B, 0, "r9_write_bypass_busy");
      push(BSY_N, 2'b01, "r9_write_nobypass_busy");
      step(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0);
      push(BV_B, 0, "r9_cleared_b");
      push(BV_N, 0, "r9_cleared_n");
      push(BSY_N, 0, "r9_rd_busy_clear");
      push(RD0_N, 32'hBB, "r9_final_data");
      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         n_bad += q.size();
         $display("FAIL pending_checks: got %0d left, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's 2R/1W register file.
- Provides NRD read ports and NWR write ports, with optional write-to-read bypass.
- Adds a per-register busy scoreboard so issue logic can detect RAW/WAW hazards for multi-cycle and out-of-order writeback units.
- Sits between decode/issue (reads, reservations) and the writeback stage(s) (writes).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; power of two, minimum 2. AW = clog2(NREG) is a derived localparam.
- NRD, 2, number of read ports (1..8).
- NWR, 2, number of write ports (1..4).
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports; when 0 reads see only the stored array.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational.
- rd_busy  out  NRD  1 = the addressed register has a pending writer.
- we  in  NWR  write enables.
- wa  in  NWR*AW  write addresses.
- wd  in  NWR*XLEN  write data.
- rsv_valid  in  1  request to mark rsv_addr busy (instruction issue).
- rsv_addr  in  AW  register to reserve.
- rsv_ok  out  1  reservation accepted this cycle (combinational).
- busy_vec  out  NREG  current scoreboard state (registered).

Behaviour:
- Reset (rst=1 at posedge):
  - All NREG registers clear to 0 and busy_vec clears to 0.
  - Writes and reservations presented in that cycle are dropped.
  - While rst=1, rsv_ok=0 and bypass is disabled.
  - After reset, every rd_data reads 0 and every rd_busy reads 0.
- Register 0:
  - Hardwired zero: reads return 0 and rd_busy=0 regardless of bypass.
  - Writes to it are ignored.
  - Reservation of register 0 is always accepted (rsv_ok=1) and never sets a busy bit.
- Write latency: a write presented with we[j]=1 at posedge N is visible in the array from cycle N+1.
- Multiple writes to the same address in one cycle: the highest-index port wins for data. The bypass uses the same priority.
- Write on a non-busy register: data is stored and busy stays 0. This is legal, not an error.
- Bypass (BYPASS=1): if any we[j] matches rd_addr[i] (non-zero), rd_data[i] = winning wd and rd_busy[i] = 0 in the same cycle.
- No bypass (BYPASS=0):
  - rd_data and rd_busy reflect the registered state only.
  - A same-cycle write is visible in rd_data from the next cycle.
  - The busy bit clears at the next edge.
- Scoreboard update at each posedge (rst=0):
  - A busy bit is cleared when any write port writes that address.
  - It is set when a reservation is accepted for it.
  - If a set and a clear hit the same address in the same cycle, set wins (the new producer owns the register).
- rsv_ok = rsv_valid & (rsv_addr==0 | ~busy[rsv_addr] | any we[j] writing rsv_addr this cycle).
  - A denied reservation (WAW stall) changes no state.
  - The requester holds rsv_valid and retries; there is no internal queue.
- busy_vec[0] is always 0.
- Reads are purely combinational: no read latency and no read enable.
- No X propagation: every output is defined from the first cycle after reset.

Decomposition:
- Package regfile_pkg holds:
  - default XLEN/NREG/NRD/NWR;
  - the ZERO_REG constant (0);
  - a function computing the winning write port for a given address (highest index).
- Natural sub-module: reg_scoreboard.
  - Contains the NREG busy flops, the set/clear priority, and rsv_ok generation.
  - Interface: clk, rst, we, wa, rsv_valid, rsv_addr, rsv_ok, busy_vec.
- The data array, write-port priority and bypass muxes stay in regfile_sb.

Test Plan:
- Reset: write 32'hDEAD_BEEF to r5, assert rst one cycle, then read r5 -> rd_data=0, busy_vec=0; rsv_ok=0 during the rst cycle.
- Register 0: write 32'hFFFF_FFFF to r0, reserve r0 -> rd_data for r0 stays 0, rsv_ok=1, busy_vec[0]=0.
- Bypass, BYPASS=1, same cycle: we[0]=1, wa=r7, wd=32'h1234_5678, rd_addr[0]=r7 -> rd_data[0]=32'h1234_5678.
- No bypass, BYPASS=0, same stimulus: rd_data[0] keeps the old value that cycle, then reads 32'h1234_5678 next cycle.
- Write-port conflict: we=2'b11, both ports address r3, wd0=32'h1, wd1=32'h2 -> r3 reads 32'h2 next cycle and the bypass gives 32'h2 in the same cycle.
- Scoreboard sequence on r9:
  1. Reserve r9 -> rsv_ok=1, busy_vec[9]=1 next cycle.
  2. Reserve r9 again -> rsv_ok=0, no change.
  3. Write r9 plus reserve r9 in the same cycle -> rsv_ok=1 and busy_vec[9] remains 1.
  4. Write r9 alone -> busy_vec[9]=0 next cycle and rd_busy reads 0.
